// File: rtl/sram_pkg.sv
// Shared constants and state encoding for the SRAM request controller.
// The SRAM macro sits beside the controller and is driven only through these encodings.
package sram_pkg;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic OP_READ  = 1'b1;
  localparam logic OP_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/sram_req_ctrl.sv
// Request controller in front of the small SRAM macro: init sweep after reset,
// then one registered SRAM access per accepted request, read data on a response channel.
module sram_req_ctrl #(
  parameter int                ADDR_W   = sram_pkg::ADDR_W,
  parameter int                DATA_W   = sram_pkg::DATA_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_select,
  output logic              sram_operation,
  output logic              sram_enable,
  output logic [DATA_W-1:0] sram_data_in,
  input  logic [DATA_W-1:0] sram_data_out
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; the producer holds its payload stable until then.

  sram_pkg::state_t  state;
  // Extra MSB flags the end of the sweep once every word has been written.
  logic [ADDR_W:0]   cnt;

  assign req_ready = (state == sram_pkg::ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= sram_pkg::ST_INIT;
      cnt            <= '0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      init_done      <= 1'b0;
      sram_enable    <= 1'b0;
      sram_operation <= sram_pkg::OP_READ;
      sram_select    <= '0;
      sram_data_in   <= '0;
    end else begin
      case (state)
        sram_pkg::ST_INIT: begin
          if (cnt[ADDR_W]) begin
            state          <= sram_pkg::ST_IDLE;
            init_done      <= 1'b1;
            sram_enable    <= 1'b0;
            sram_operation <= sram_pkg::OP_READ;
          end else begin
            sram_enable    <= 1'b1;
            sram_operation <= sram_pkg::OP_WRITE;
            sram_select    <= cnt[ADDR_W-1:0];
            sram_data_in   <= INIT_VAL;
            cnt            <= cnt + 1'b1;
          end
        end
        sram_pkg::ST_IDLE: begin
          if (req_valid) begin
            sram_enable    <= 1'b1;
            sram_operation <= req_write ? sram_pkg::OP_WRITE : sram_pkg::OP_READ;
            sram_select    <= req_addr;
            sram_data_in   <= req_wdata;
            state          <= sram_pkg::ST_ACCESS;
          end
        end
        sram_pkg::ST_ACCESS: begin
          // The SRAM pins held the access for this whole cycle; close it out.
          sram_enable    <= 1'b0;
          sram_operation <= sram_pkg::OP_READ;
          if (sram_operation == sram_pkg::OP_READ) begin
            rsp_rdata <= sram_data_out;
            rsp_valid <= 1'b1;
            state     <= sram_pkg::ST_RESP;
          end else begin
            state <= sram_pkg::ST_IDLE;
          end
        end
        sram_pkg::ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= sram_pkg::ST_IDLE;
          end
        end
        default: state <= sram_pkg::ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl with a behavioural 4x4 SRAM model beside it.
// Directed requests push expected read data; a negedge monitor pops and compares.
module tb_sram_req_ctrl;

  localparam int AW = 2;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic [AW-1:0] sram_select;
  logic          sram_operation;
  logic          sram_enable;
  logic [DW-1:0] sram_data_in;
  logic [DW-1:0] sram_data_out;

  sram_req_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .init_done      (init_done),
    .sram_select    (sram_select),
    .sram_operation (sram_operation),
    .sram_enable    (sram_enable),
    .sram_data_in   (sram_data_in),
    .sram_data_out  (sram_data_out)
  );

  // ---------------- clock / reset / SRAM model ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [4];
  logic          mem_fill = 1'b1;

  assign sram_data_out = mem[sram_select];

  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 4; i++) mem[i] <= 4'hF;
    end else if (sram_enable && !sram_operation) begin
      mem[sram_select] <= sram_data_in;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q [$];
  int            lat_q [$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            last_acc = -10;
  int            last_wr_acc = -10;
  bit            mon_on = 1'b0;
  bit            prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (rsp_valid) begin
        if (!prev_valid) begin
          if (lat_q.size() == 0) check("rsp_unexpected", 1, 0);
          else check("rsp_latency", cyc, lat_q.pop_front());
        end
        if (exp_q.size() == 0) check("rsp_no_expect", 1, 0);
        else check("rsp_rdata", rsp_rdata, exp_q[0]);
        check("req_ready_in_resp", req_ready, 0);
        check("enable_in_resp", sram_enable, 0);
        if (rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (req_ready) check("enable_in_idle", sram_enable, 0);
      if (!sram_operation) check("write_cycle_legal", cyc, last_wr_acc + 1);
    end
    prev_valid = rsp_valid && !rst;
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int waited;
    waited    = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("req_accept_timeout", 0, 1);
    end else begin
      last_acc = cyc;
      if (w) last_wr_acc = cyc;
      else begin
        exp_q.push_back(d);
        lat_q.push_back(cyc + 2);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while (!(req_ready && !rsp_valid) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!(req_ready && !rsp_valid)) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_rsp();
    int waited;
    waited = 0;
    while (!rsp_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!rsp_valid) check("rsp_timeout", 0, 1);
  endtask

  // Entered at the negedge where rst has just been dropped.
  task automatic check_init();
    check("init_c0_req_ready", req_ready, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("init_enable", sram_enable, 1);
      check("init_operation", sram_operation, 0);
      check("init_select", sram_select, i);
      check("init_data_in", sram_data_in, 0);
      check("init_req_ready", req_ready, 0);
      check("init_done_early", init_done, 0);
    end
    @(negedge clk);
    check("init_done", init_done, 1);
    check("init_req_ready_after", req_ready, 1);
    check("init_enable_after", sram_enable, 0);
    check("init_operation_after", sram_operation, 1);
    for (int i = 0; i < 4; i++) check("init_mem_zero", mem[i], 0);
  endtask

  // ---------------- stimulus ----------------
  int a1;

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_enable", sram_enable, 0);
    check("rst_operation", sram_operation, 1);
    check("rst_select", sram_select, 0);
    check("rst_data_in", sram_data_in, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_init_done", init_done, 0);
    mem_fill = 1'b0;
    rst      = 1'b0;
    check_init();
    mon_on = 1'b1;

    // Write sweep then read sweep
    do_req(1'b1, 2'd0, 4'b1010);
    do_req(1'b1, 2'd1, 4'b1100);
    do_req(1'b1, 2'd2, 4'b0110);
    do_req(1'b1, 2'd3, 4'b0011);
    do_req(1'b0, 2'd0, 4'b1010);
    do_req(1'b0, 2'd1, 4'b1100);
    do_req(1'b0, 2'd2, 4'b0110);
    do_req(1'b0, 2'd3, 4'b0011);
    wait_idle();

    // Backpressure: five cycles with rsp_ready low
    rsp_ready = 1'b0;
    do_req(1'b0, 2'd1, 4'b1100);
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_rdata", rsp_rdata, 4'b1100);
      check("bp_req_ready", req_ready, 0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk);
    #2 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_req_ready", req_ready, 0);
    @(negedge clk);
    check("bp_after_req_ready", req_ready, 1);
    check("bp_after_valid", rsp_valid, 0);

    // Write then read same address, request held back-to-back
    do_req(1'b1, 2'd2, 4'b1111);
    a1 = last_acc;
    do_req(1'b0, 2'd2, 4'b1111);
    check("b2b_accept_gap", last_acc - a1, 2);
    wait_idle();

    // Reset while a response is pending
    do_req(1'b1, 2'd2, 4'b0110);
    rsp_ready = 1'b0;
    do_req(1'b0, 2'd2, 4'b0110);
    wait_rsp();
    check("mid_rdata", rsp_rdata, 4'b0110);
    mon_on = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_init_done", init_done, 0);
    check("mid_rst_req_ready", req_ready, 0);
    exp_q.delete();
    lat_q.delete();
    rsp_ready = 1'b1;
    rst       = 1'b0;
    check_init();
    mon_on = 1'b1;
    do_req(1'b0, 2'd2, 4'b0000);
    do_req(1'b0, 2'd0, 4'b0000);
    wait_idle();
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
- Clocked request controller directly upstream of the 4x4 SRAM macro; sole driver of its select/operation/enable/data_in pins.
- Converts a valid/ready request stream (read/write, address, data) into correctly sequenced SRAM accesses.
- Returns read data on a valid/ready response channel.
- After reset, initialises every SRAM word to INIT_VAL before accepting requests.

Parameters:
- ADDR_W, 2, address width; SRAM depth = 2**ADDR_W = 4 words
- DATA_W, 4, word width
- INIT_VAL, 4'b0000, value written to every word during the init sweep

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller accepts request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  read data
- init_done  out  1  init sweep complete; sticky until rst
- sram_select  out  ADDR_W  to SRAM select
- sram_operation  out  1  to SRAM operation; 1 = read, 0 = write
- sram_enable  out  1  to SRAM enable
- sram_data_in  out  DATA_W  to SRAM data_in
- sram_data_out  in  DATA_W  from SRAM data_out

Behaviour:
- Reset values:
  - state = INIT, init counter = 0.
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, init_done = 0.
  - sram_enable = 0, sram_operation = 1, sram_select = 0, sram_data_in = 0.
- All sram_* outputs are registered.
- sram_operation = 0 only in cycles that perform a write; it is 1 at all other times, so no spurious writes occur.
- States: INIT, IDLE, ACCESS, RESP.
- INIT:
  - Each cycle drives sram_enable = 1, sram_operation = 0, sram_select = cnt, sram_data_in = INIT_VAL.
  - cnt increments 0..3. After the cnt = 3 write cycle: go to IDLE, set init_done = 1, sram_enable = 0.
  - INIT lasts exactly 4 cycles after rst deasserts.
  - req_ready = 0 throughout.
- IDLE:
  - req_ready = 1 (combinational from state == IDLE); sram_enable = 0.
  - On req_valid & req_ready: latch write/addr/wdata into sram_* registers, set sram_enable = 1, go to ACCESS.
- ACCESS (one cycle):
  - SRAM pins hold latched values for the whole cycle.
  - Write: return to IDLE; sram_enable = 0 and sram_operation = 1 next cycle. No response is generated.
  - Read: sample sram_data_out at the end of the cycle into rsp_rdata, set rsp_valid = 1, go to RESP, sram_enable = 0.
- RESP:
  - rsp_valid and rsp_rdata are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid = 0, go to IDLE.
  - req_ready = 0 while in RESP.
- Latency (request accepted in cycle N):
  - SRAM access occurs in cycle N+1.
  - Write: req_ready is high again in N+2.
  - Read: rsp_valid rises in N+2. With rsp_ready held high, rsp_valid is cleared in N+3 and req_ready is high in N+3.
- Throughput: at most one request every 2 cycles (write) or 3 cycles (read, no backpressure).
- Boundaries:
  - Addresses 0..3 are all legal; no wrap logic is needed.
  - A read immediately following a write to the same address returns the new data, because the write completes in ACCESS before the read is accepted.
  - req_valid during INIT or RESP is ignored; the requester must hold it high.
- Reset mid-operation:
  - rst in any state aborts the operation; any pending response is dropped (rsp_valid = 0).
  - init_done clears and the INIT sweep restarts, zeroing all words.

Decomposition:
- Shared package sram_pkg:
  - ADDR_W, DATA_W, DEPTH constants.
  - OP_READ = 1'b1, OP_WRITE = 1'b0 constants.
  - State encoding constants ST_INIT, ST_IDLE, ST_ACCESS, ST_RESP.
- No sub-module: a single FSM plus init counter. The SRAM is instantiated beside it by the parent, not inside it.

Test Plan:
- Reset/init: pulse rst 2 cycles, release.
  - Expected: exactly 4 write cycles to addresses 0,1,2,3 with data 0000; init_done = 1 in the 5th cycle; req_ready stays 0 until then.
- Write sweep then read sweep:
  - Stimulus: write 1010@00, 1100@01, 0110@10, 0011@11; then read 00..11 with rsp_ready = 1.
  - Expected: rsp_rdata = 1010, 1100, 0110, 0011 in order, each at N+2.
- Backpressure:
  - Stimulus: read @01 with rsp_ready = 0 for 5 cycles, then 1.
  - Expected: rsp_valid high and rsp_rdata = 1100 stable for all 5 cycles; req_ready = 0 until the handshake; req_ready = 1 the cycle after.
- Write-then-read same address:
  - Stimulus: write 1111@10, then read @10 back-to-back with req_valid held.
  - Expected: read returns 1111; second request accepted exactly 2 cycles after the first.
- Reset mid-read:
  - Stimulus: assert rst during RESP holding 0110.
  - Expected: rsp_valid = 0 the next cycle and the init sweep restarts; a subsequent read @10 returns 0000.
- No spurious writes:
  - Check: in every non-INIT, non-write-ACCESS cycle, sram_operation == 1; sram_enable == 0 in IDLE and RESP.
